and_gate_bus_arbiter: RTL and testbench

//   Round-robin arbiter that shares one backplane bus among NUM_REQ requesters.

---
 rtl/and_gate_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_and_gate_bus_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/and_gate_bus_arbiter.sv
// ============================================================================
//  Module   : and_gate_bus_arbiter
//  Brief    : Round-robin backplane bus arbiter with a one-cycle dead gap
//             between grants. Optional hold timeout via ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_gate_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic                       timeout
);

    localparam int                c_ID_W    = $clog2(NUM_REQ);
    localparam logic [1:0]        c_IDLE    = 2'd0;
    localparam logic [1:0]        c_GRANT   = 2'd1;
    localparam logic [1:0]        c_GAP     = 2'd2;
    localparam logic [c_ID_W-1:0] c_PTR_RST = c_ID_W'(NUM_REQ - 1);

    generate
        if ((NUM_REQ < 2) || (NUM_REQ > 4) || ((2 ** CNT_W) <= HOLD_MAX)) begin : g_param_chk
            $error("and_gate_bus_arbiter: illegal NUM_REQ/CNT_W/HOLD_MAX combination");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [c_ID_W-1:0]  r_gnt_id;
    logic [c_ID_W-1:0]  r_ptr;
    logic               r_busy;

    logic               w_found;
    logic [c_ID_W-1:0]  w_win;
    logic [NUM_REQ-1:0] w_win_oh;
    logic               w_owner_req;
    logic               w_force;
    logic               w_release;

    // Scan from the farthest position back to ptr+1 so the nearest requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_win_oh = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                w_found = 1'b1;
                w_win   = c_ID_W'(idx);
            end
        end
        if (w_found) begin
            w_win_oh[w_win] = 1'b1;
        end
    end

    assign w_owner_req = req[r_gnt_id];
    assign w_release   = !w_owner_req || w_force;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= c_PTR_RST;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_GAP: begin
                    if (w_found) begin
                        r_gnt    <= w_win_oh;
                        r_gnt_id <= w_win;
                        r_busy   <= 1'b1;
                        r_state  <= c_GRANT;
                    end else begin
                        r_gnt    <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= c_IDLE;
                    end
                end
                c_GRANT: begin
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_gnt_id;
                        r_state <= c_GAP;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_HOLD_MAX = CNT_W'(HOLD_MAX);

    logic [CNT_W-1:0] r_hold;
    logic             r_timeout;

    // Counter idles at zero outside GRANT, so every new grant starts from zero.
    assign w_force = (r_state == c_GRANT) && w_owner_req && (r_hold == c_HOLD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if ((r_state != c_GRANT) || w_release) begin
                r_hold <= '0;
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_and_gate_bus_arbiter.sv
// ============================================================================
//  Module   : tb_and_gate_bus_arbiter
//  Brief    : Directed-vector self-checking bench for and_gate_bus_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_and_gate_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    and_gate_bus_arbiter #(
        .NUM_REQ  (4),
        .HOLD_MAX (15),
        .CNT_W    (4)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [3:0] prev_gnt;
        int         viol;
        int         held;
        int         to_cnt;
        int         order [5] = '{0, 1, 2, 3, 0};

        // reset state
        repeat (2) tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_gnt_id", 32'(gnt_id), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst = 1'b0;

        // reset while a grant is active
        req = 4'b1111;
        tick();
        check("t1_first_gnt", 32'(gnt), 32'h1);
        tick();
        tick();
        check("t1_held", 32'(gnt), 32'h1);
        #3 rst = 1'b1;
        #1;
        check("t1_async_gnt", 32'(gnt), 32'h0);
        check("t1_async_busy", 32'(busy), 32'h0);
        #1 rst = 1'b0;
        tick();
        check("t1_post_rst_gnt", 32'(gnt), 32'h1);
        check("t1_post_rst_id", 32'(gnt_id), 32'h0);
        req = 4'b0000;
        tick();
        tick();

        // single requester
        req = 4'b0100;
        tick();
        check("t2_gnt", 32'(gnt), 32'h4);
        check("t2_id", 32'(gnt_id), 32'h2);
        check("t2_busy", 32'(busy), 32'h1);
        repeat (4) tick();
        check("t2_hold", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick();
        check("t2_rel_gnt", 32'(gnt), 32'h0);
        check("t2_rel_busy", 32'(busy), 32'h0);
        check("t2_id_kept", 32'(gnt_id), 32'h2);
        tick();
        tick();
        check("t2_no_regrant", 32'(gnt), 32'h0);

        // round robin with all requesting
        do_reset();
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_gnt", 32'(gnt), 32'(1 << order[i]));
            check("t3_id", 32'(gnt_id), 32'(order[i]));
            tick();
            tick();
            check("t3_gnt_c3", 32'(gnt), 32'(1 << order[i]));
            if (i < 4) begin
                req[order[i]] = 1'b0;
                tick();
                check("t3_gap", 32'(gnt), 32'h0);
                req[order[i]] = 1'b1;
                tick();
            end
        end
        req = 4'b0000;
        tick();
        tick();

        // owner releases on the same edge another request rises
        do_reset();
        req = 4'b0010;
        tick();
        check("t4_owner1", 32'(gnt), 32'h2);
        req = 4'b1000;
        tick();
        check("t4_gap_gnt", 32'(gnt), 32'h0);
        check("t4_gap_busy", 32'(busy), 32'h0);
        tick();
        check("t4_new_gnt", 32'(gnt), 32'h8);
        check("t4_new_id", 32'(gnt_id), 32'h3);
        req = 4'b0000;
        tick();
        tick();

        // hold timeout
        do_reset();
        req = 4'b0011;
        tick();
        held   = 0;
        to_cnt = 0;
`ifdef ARB_TIMEOUT_EN
        while (gnt == 4'b0001 && held < 40) begin
            held++;
            if (timeout) to_cnt++;
            tick();
        end
        check("t5_held_cycles", 32'(held), 32'd16);
        check("t5_to_during_hold", 32'(to_cnt), 32'd0);
        check("t5_rel_gnt", 32'(gnt), 32'h0);
        check("t5_timeout_pulse", 32'(timeout), 32'h1);
        tick();
        check("t5_timeout_clear", 32'(timeout), 32'h0);
        check("t5_owner1", 32'(gnt), 32'h2);
`else
        for (int c = 0; c < 120; c++) begin
            if (gnt == 4'b0001) held++;
            if (timeout) to_cnt++;
            tick();
        end
        check("t5_held_cycles", 32'(held), 32'd120);
        check("t5_no_timeout", 32'(to_cnt), 32'd0);
        check("t5_still_owner0", 32'(gnt), 32'h1);
`endif
        req = 4'b0000;
        tick();
        tick();

        // random invariants
        viol     = 0;
        prev_gnt = gnt;
        for (int c = 0; c < 10000; c++) begin
            req = 4'($urandom_range(0, 15));
            tick();
            if ((gnt & (gnt - 4'd1)) != 4'b0000) viol++;
            if (busy != (gnt != 4'b0000)) viol++;
            if (busy && (gnt != (4'b0001 << gnt_id))) viol++;
            if ((prev_gnt != 4'b0000) && (gnt != 4'b0000) && (gnt != prev_gnt)) viol++;
            prev_gnt = gnt;
        end
        check("t6_invariant_viol", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
